// File: rtl/uart_led_cmd_pkg.sv
// Shared command/reply codes, FSM states and timeout helper
// for the uart LED command endpoint.
package uart_led_cmd_pkg;

  localparam logic [7:0] CMD_SET     = 8'h53;
  localparam logic [7:0] CMD_TOGGLE  = 8'h54;
  localparam logic [7:0] CMD_GET     = 8'h47;

  localparam logic [7:0] RSP_OK      = 8'h4B;
  localparam logic [7:0] RSP_ERR     = 8'h3F;
  localparam logic [7:0] RSP_TIMEOUT = 8'h21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ARG,
    ST_REPLY_REQ,
    ST_REPLY_WAIT
  } state_t;

  function automatic int unsigned timeout_cycles(
    input int unsigned clk_hz,
    input int unsigned ms
  );
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/uart_led_cmd_timeout.sv
// cmd_timeout: down-counter reloaded while clear=1, expired when it hits 0.
// Ports: clk, rst_n (async low), clear, expired.
module cmd_timeout #(
  parameter int unsigned CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= LOAD;
    end else if (clear) begin
      r_cnt <= LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = (r_cnt == '0) && !clear;

endmodule

// File: rtl/uart_led_cmd.sv
// uart_led_cmd: decodes S/T/G byte commands, drives LEDs, replies 1 byte.
// Ports: clk, rst_n, rx_data/rx_valid in, tx_start/tx_data out, tx_busy in, led out.
import uart_led_cmd_pkg::*;

module uart_led_cmd #(
  parameter int unsigned INPUT_CLOCK    = 27000000,
  parameter int unsigned LED_WIDTH      = 6,
  parameter int unsigned LED_ACTIVE_LOW = 1,
  parameter int unsigned TIMEOUT_MS     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [LED_WIDTH-1:0] led
);

  localparam int unsigned TIMEOUT_CYCLES =
    timeout_cycles(INPUT_CLOCK, TIMEOUT_MS);
  localparam logic [LED_WIDTH-1:0] LED_OFF =
    (LED_ACTIVE_LOW != 0) ? '1 : '0;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_toggle;
  logic                  w_toggle_nxt;
  logic [LED_WIDTH-1:0]  r_led_state;
  logic [LED_WIDTH-1:0]  w_led_nxt;
  logic [LED_WIDTH-1:0]  r_led;
  logic [7:0]            r_tx_data;
  logic [7:0]            w_tx_data_nxt;
  logic                  r_tx_start;
  logic                  w_tx_start_nxt;
  logic                  w_expired;
  logic                  w_tmo_clear;
  logic [LED_WIDTH-1:0]  w_arg;
  logic [7:0]            w_get_rsp;
  logic                  w_is_set;
  logic                  w_is_tog;
  logic                  w_is_get;

  assign w_tmo_clear = (r_state != ST_WAIT_ARG);
  assign w_arg       = rx_data[LED_WIDTH-1:0];
  assign w_is_set    = (rx_data == CMD_SET);
  assign w_is_tog    = (rx_data == CMD_TOGGLE);
  assign w_is_get    = (rx_data == CMD_GET);

  always_comb begin
    w_get_rsp = '0;
    w_get_rsp[LED_WIDTH-1:0] = r_led_state;
  end

  cmd_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_tmo_clear),
    .expired (w_expired)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_toggle_nxt   = r_toggle;
    w_led_nxt      = r_led_state;
    w_tx_data_nxt  = r_tx_data;
    w_tx_start_nxt = r_tx_start;
    unique case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          unique case (1'b1)
            w_is_set || w_is_tog: begin
              w_state_nxt  = ST_WAIT_ARG;
              w_toggle_nxt = w_is_tog;
            end
            w_is_get: begin
              w_state_nxt    = ST_REPLY_REQ;
              w_tx_data_nxt  = w_get_rsp;
              w_tx_start_nxt = !tx_busy;
            end
            default: begin
              w_state_nxt    = ST_REPLY_REQ;
              w_tx_data_nxt  = RSP_ERR;
              w_tx_start_nxt = !tx_busy;
            end
          endcase
        end
      end
      ST_WAIT_ARG: begin
        // A byte on the expiry cycle still counts as the argument.
        if (rx_valid) begin
          w_led_nxt      = r_toggle ? (r_led_state ^ w_arg) : w_arg;
          w_state_nxt    = ST_REPLY_REQ;
          w_tx_data_nxt  = RSP_OK;
          w_tx_start_nxt = !tx_busy;
        end else if (w_expired) begin
          w_state_nxt    = ST_REPLY_REQ;
          w_tx_data_nxt  = RSP_TIMEOUT;
          w_tx_start_nxt = !tx_busy;
        end
      end
      ST_REPLY_REQ: begin
        // Busy before our request is a foreign transfer: wait it out.
        if (r_tx_start) begin
          if (tx_busy) begin
            w_tx_start_nxt = 1'b0;
            w_state_nxt    = ST_REPLY_WAIT;
          end
        end else if (!tx_busy) begin
          w_tx_start_nxt = 1'b1;
        end
      end
      ST_REPLY_WAIT: begin
        if (!tx_busy) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_toggle    <= 1'b0;
      r_led_state <= '0;
      r_led       <= LED_OFF;
      r_tx_data   <= 8'h00;
      r_tx_start  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_toggle    <= w_toggle_nxt;
      r_led_state <= w_led_nxt;
      r_led       <= (LED_ACTIVE_LOW != 0) ? ~w_led_nxt : w_led_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_start  <= w_tx_start_nxt;
    end
  end

  assign led      = r_led;
  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;

endmodule

// File: tb/tb_uart_led_cmd.sv
// Scoreboard bench for uart_led_cmd: directed commands, queued replies,
// a uart busy model and a monitor that checks each tx request.
module tb_uart_led_cmd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [5:0] led;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  bit stuck = 1'b0;

  uart_led_cmd #(
    .INPUT_CLOCK    (10000),
    .LED_WIDTH      (6),
    .LED_ACTIVE_LOW (1),
    .TIMEOUT_MS     (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // uart model: busy rises 3 clk after start, holds 20 clk
  int dly = 0;
  int hold = 0;
  always @(negedge clk) begin
    if (!rst_n || stuck) begin
      tx_busy = 1'b0;
      dly = 0;
      hold = 0;
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) tx_busy = 1'b0;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        tx_busy = 1'b1;
        hold = 20;
      end
    end else if (tx_start) begin
      dly = 3;
    end
  end

  // monitor: one pop per tx_start rise, data stable while held
  logic       prev_start = 1'b0;
  logic [7:0] held = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
    end else begin
      if (tx_start && !prev_start) begin
        held = tx_data;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_reply: got %0h expected none", tx_data);
        end else begin
          check("reply", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
      end else if (tx_start) begin
        check("tx_data_stable", {24'h0, tx_data}, {24'h0, held});
      end
      prev_start = tx_start;
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_start && !tx_busy) break;
    end
    check(nm, (i < 300) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_led", {26'h0, led}, 32'h3F);
    check("rst_start", {31'h0, tx_start}, 32'h0);
    check("rst_data", {24'h0, tx_data}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: set, latency one clk
    send(8'h53);
    exp_q.push_back(8'h4B);
    send(8'h2A);
    check("t1_led", {26'h0, led}, 32'h15);
    check("t1_lat_start", {31'h0, tx_start}, 32'h1);
    wait_done("t1_done");

    // 2: set, toggle, get
    exp_q.push_back(8'h4B);
    send(8'h53);
    send(8'h0F);
    wait_done("t2a_done");
    check("t2_led_set", {26'h0, led}, 32'h30);
    exp_q.push_back(8'h4B);
    send(8'h54);
    send(8'hFF);
    wait_done("t2b_done");
    check("t2_led_tog", {26'h0, led}, 32'h0F);
    exp_q.push_back(8'h30);
    send(8'h47);
    wait_done("t2c_done");

    // 3: timeout fires on clk 99, arg on clk 99 wins
    exp_q.push_back(8'h21);
    send(8'h54);
    repeat (99) @(negedge clk);
    check("t3_to_early", {31'h0, tx_start}, 32'h0);
    @(negedge clk);
    check("t3_to_fire", {31'h0, tx_start}, 32'h1);
    wait_done("t3a_done");
    check("t3_led_keep", {26'h0, led}, 32'h0F);
    exp_q.push_back(8'h4B);
    send(8'h54);
    repeat (99) @(negedge clk);
    send(8'h01);
    wait_done("t3b_done");
    check("t3_led_edge", {26'h0, led}, 32'h0E);

    // 4: unknown byte, bytes during reply discarded
    exp_q.push_back(8'h3F);
    send(8'h41);
    for (int i = 0; i < 50 && !tx_busy; i++) @(negedge clk);
    check("t4_busy_seen", {31'h0, tx_busy}, 32'h1);
    send(8'h47);
    send(8'h53);
    send(8'h00);
    wait_done("t4_done");
    check("t4_led_keep", {26'h0, led}, 32'h0E);

    // 5: busy stuck low, request held
    stuck = 1'b1;
    exp_q.push_back(8'h31);
    send(8'h47);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_start) cnt++;
    end
    check("t5_start_held", cnt, 32'd50);
    stuck = 1'b0;
    wait_done("t5_done");

    // 6: reset in WAIT_ARG and in REPLY_REQ
    send(8'h53);
    rst_n = 1'b0;
    #1;
    check("t6a_led", {26'h0, led}, 32'h3F);
    check("t6a_start", {31'h0, tx_start}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stuck = 1'b1;
    exp_q.push_back(8'h00);
    send(8'h47);
    repeat (3) @(negedge clk);
    check("t6b_req", {31'h0, tx_start}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6b_start", {31'h0, tx_start}, 32'h0);
    check("t6b_led", {26'h0, led}, 32'h3F);
    @(negedge clk);
    rst_n = 1'b1;
    stuck = 1'b0;
    @(negedge clk);
    exp_q.push_back(8'h00);
    send(8'h47);
    wait_done("t6c_done");

    // arg bits above LED width ignored
    exp_q.push_back(8'h4B);
    send(8'h53);
    send(8'hC5);
    wait_done("t7a_done");
    check("t7_led", {26'h0, led}, 32'h3A);
    exp_q.push_back(8'h05);
    send(8'h47);
    wait_done("t7b_done");

    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
